// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the WT cache memory request channel between I$ and D$.
// Build option WT_ARB_DCACHE_PRIO_EN: fixed D$ priority instead of round-robin.
module wt_mem_req_arbiter #(
    parameter int unsigned ReqDataWidth   = 256,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ic_req_i,
    output logic                    ic_ack_o,
    input  logic [ReqDataWidth-1:0] ic_data_i,
    input  logic                    dc_req_i,
    output logic                    dc_ack_o,
    input  logic [ReqDataWidth-1:0] dc_data_i,
    output logic                    mem_req_o,
    input  logic                    mem_ack_i,
    output logic [ReqDataWidth-1:0] mem_data_o,
    output logic                    mem_src_o,
    input  logic                    mem_rtrn_vld_i,
    input  logic                    mem_rtrn_src_i,
    output logic                    ic_rtrn_vld_o,
    output logic                    dc_rtrn_vld_o,
    output logic [CntWidth-1:0]     ic_outstanding_o,
    output logic [CntWidth-1:0]     dc_outstanding_o,
    output logic                    idle_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_IC,
        GNT_DC
    } state_e;

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] ic_cnt_q, ic_cnt_d;
    logic [CntWidth-1:0] dc_cnt_q, dc_cnt_d;
    logic                err_q, err_d;
    logic                ic_elig, dc_elig;
    logic                prefer_dc;

    assign ic_elig = ic_req_i && (ic_cnt_q < MaxCnt);
    assign dc_elig = dc_req_i && (dc_cnt_q < MaxCnt);

`ifdef WT_ARB_DCACHE_PRIO_EN
    assign prefer_dc = 1'b1;
`else
    logic last_dc_q, last_dc_d;

    // Reset points at D$ so the I$ wins the first tie.
    always_comb begin
        last_dc_d = last_dc_q;
        if (ic_ack_o) begin
            last_dc_d = 1'b0;
        end else if (dc_ack_o) begin
            last_dc_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_dc_q <= 1'b1;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end

    assign prefer_dc = !last_dc_q;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_data_o = '0;
        mem_src_o  = 1'b0;
        ic_ack_o   = 1'b0;
        dc_ack_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ic_elig && dc_elig) begin
                    state_d = prefer_dc ? GNT_DC : GNT_IC;
                end else if (ic_elig) begin
                    state_d = GNT_IC;
                end else if (dc_elig) begin
                    state_d = GNT_DC;
                end
            end
            GNT_IC: begin
                mem_req_o  = 1'b1;
                mem_data_o = ic_data_i;
                if (mem_ack_i) begin
                    ic_ack_o = 1'b1;
                    state_d  = IDLE;
                end
            end
            GNT_DC: begin
                mem_req_o  = 1'b1;
                mem_data_o = dc_data_i;
                mem_src_o  = 1'b1;
                if (mem_ack_i) begin
                    dc_ack_o = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ic_rtrn_vld_o = mem_rtrn_vld_i && !mem_rtrn_src_i;
    assign dc_rtrn_vld_o = mem_rtrn_vld_i && mem_rtrn_src_i;

    // A return against an empty counter is a protocol error, never a wrap.
    function automatic logic [CntWidth-1:0] next_cnt(
        input logic [CntWidth-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        logic [CntWidth-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CntWidth'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CntWidth'(1);
        end
        return res;
    endfunction

    always_comb begin
        ic_cnt_d = next_cnt(ic_cnt_q, ic_ack_o, ic_rtrn_vld_o);
        dc_cnt_d = next_cnt(dc_cnt_q, dc_ack_o, dc_rtrn_vld_o);
        err_d    = err_q
                 | (ic_rtrn_vld_o && (ic_cnt_q == '0))
                 | (dc_rtrn_vld_o && (dc_cnt_q == '0))
                 | ((state_q == GNT_IC) && !ic_req_i)
                 | ((state_q == GNT_DC) && !dc_req_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ic_cnt_q <= '0;
            dc_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ic_cnt_q <= ic_cnt_d;
            dc_cnt_q <= dc_cnt_d;
            err_q    <= err_d;
        end
    end

    assign ic_outstanding_o = ic_cnt_q;
    assign dc_outstanding_o = dc_cnt_q;
    assign idle_o = (state_q == IDLE) && (ic_cnt_q == '0) && (dc_cnt_q == '0);
    assign err_o  = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Scoreboard bench for wt_mem_req_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_wt_mem_req_arbiter;

    localparam int W  = 256;
    localparam int MO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0, dc_req = 1'b0;
    logic [W-1:0]  ic_data = '0, dc_data = '0;
    logic          mem_ack = 1'b0, rtrn_vld = 1'b0, rtrn_src = 1'b0;
    logic          ic_ack_o, dc_ack_o, mem_req_o, mem_src_o;
    logic [W-1:0]  mem_data_o;
    logic          ic_rtrn_vld_o, dc_rtrn_vld_o, idle_o, err_o;
    logic [CW-1:0] ic_out_o, dc_out_o;

    wt_mem_req_arbiter #(.ReqDataWidth(W), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ic_req_i(ic_req), .ic_ack_o(ic_ack_o), .ic_data_i(ic_data),
        .dc_req_i(dc_req), .dc_ack_o(dc_ack_o), .dc_data_i(dc_data),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack),
        .mem_data_o(mem_data_o), .mem_src_o(mem_src_o),
        .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_src_i(rtrn_src),
        .ic_rtrn_vld_o(ic_rtrn_vld_o), .dc_rtrn_vld_o(dc_rtrn_vld_o),
        .ic_outstanding_o(ic_out_o), .dc_outstanding_o(dc_out_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit           src;
        logic [W-1:0] data;
    } txn_t;
    txn_t exp_q[$];

    // Reference model: who holds the channel (0 none, 1 I$, 2 D$),
    // per-requester in-flight counts, last winner, sticky error.
    int m_gnt;
    int m_cnt[2];
    int m_last;
    bit m_err;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last = 1;
        m_err = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_req = 0; dc_req = 0; mem_ack = 0; rtrn_vld = 0; rtrn_src = 0;
        ic_data = '0; dc_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_ic_cnt", ic_out_o, 0);
        chk("rst_dc_cnt", dc_out_o, 0);
        chk("rst_src", mem_src_o, 0);
        chk("rst_data", mem_data_o, 0);
        chk("rst_acks", {ic_ack_o, dc_ack_o}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock of stimulus; outputs are checked at the falling edge,
    // then the model advances to the next rising edge.
    task automatic step(input bit ir, input bit dr, input bit ak,
                        input bit rv, input bit rs,
                        input logic [W-1:0] id, input logic [W-1:0] dd);
        int  acked;
        int  nxt;
        bit  e_ic, e_dc;
        @(posedge clk);
        #1;
        chk("ack_pending", exp_q.size(), 0);
        ic_req = ir; dc_req = dr; ic_data = id; dc_data = dd;
        mem_ack = ak; rtrn_vld = rv; rtrn_src = rs;
        if (m_gnt != 0 && ak) begin
            exp_q.push_back('{src: (m_gnt == 2), data: (m_gnt == 2) ? dd : id});
        end
        @(negedge clk);
        chk("mem_req", mem_req_o, m_gnt != 0);
        if (m_gnt != 0) begin
            chk("mem_src", mem_src_o, m_gnt == 2);
            chk("mem_data", mem_data_o, (m_gnt == 2) ? dd : id);
        end
        chk("ic_rtrn", ic_rtrn_vld_o, rv && !rs);
        chk("dc_rtrn", dc_rtrn_vld_o, rv && rs);
        chk("ic_cnt", ic_out_o, m_cnt[0]);
        chk("dc_cnt", dc_out_o, m_cnt[1]);
        chk("err", err_o, m_err);
        chk("idle", idle_o, m_gnt == 0 && m_cnt[0] == 0 && m_cnt[1] == 0);

        acked = (m_gnt != 0 && ak) ? m_gnt - 1 : -1;
        nxt = m_gnt;
        if (m_gnt == 0) begin
            e_ic = ir && m_cnt[0] < MO;
            e_dc = dr && m_cnt[1] < MO;
`ifdef WT_ARB_DCACHE_PRIO_EN
            if (e_dc) nxt = 2;
            else if (e_ic) nxt = 1;
`else
            if (e_ic && e_dc) nxt = (m_last == 1) ? 1 : 2;
            else if (e_ic) nxt = 1;
            else if (e_dc) nxt = 2;
`endif
        end else begin
            if ((m_gnt == 1 && !ir) || (m_gnt == 2 && !dr)) m_err = 1;
            if (ak) begin
                m_last = m_gnt - 1;
                nxt = 0;
            end
        end
        for (int x = 0; x < 2; x++) begin
            bit a, r;
            a = (acked == x);
            r = rv && (rs == x);
            if (r && m_cnt[x] == 0) m_err = 1;
            if (a && !r) m_cnt[x]++;
            else if (r && !a && m_cnt[x] > 0) m_cnt[x]--;
        end
        m_gnt = nxt;
    endtask

    // Monitor: every acceptance pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst_n && (ic_ack_o || dc_ack_o)) begin
            chk("ack_exclusive", ic_ack_o && dc_ack_o, 0);
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 1, 0);
            end else begin
                txn_t t;
                t = exp_q.pop_front();
                chk("ack_src", dc_ack_o, t.src);
                chk("ack_data", mem_data_o, t.data);
            end
        end
    end

    localparam logic [W-1:0] DA5 = 256'hA5;
    localparam logic [W-1:0] D3C = 256'h3C;

    initial begin
        bit           exp_dc;
        bit           ic_pend, dc_pend;
        logic [W-1:0] ic_v, dc_v;

        do_reset();

        // single I$ request, ack in cycle 3
        step(1, 0, 0, 0, 0, DA5, 0);
        chk("t1_req_c0", mem_req_o, 0);
        step(1, 0, 0, 0, 0, DA5, 0);
        chk("t1_req_c1", mem_req_o, 1);
        chk("t1_data", mem_data_o, DA5);
        step(1, 0, 0, 0, 0, DA5, 0);
        step(1, 0, 1, 0, 0, DA5, 0);
        chk("t1_ack_c3", ic_ack_o, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t1_cnt_c4", ic_out_o, 1);

        // fill I$ credits, then a return reopens the grant
        repeat (6) step(1, 0, 1, 0, 0, DA5, 0);
        repeat (4) begin
            step(1, 0, 1, 0, 0, DA5, 0);
            chk("sat_blocked", mem_req_o, 0);
        end
        chk("sat_cnt", ic_out_o, 4);
        step(1, 0, 1, 1, 0, DA5, 0);
        chk("sat_rtrn", ic_rtrn_vld_o, 1);
        step(1, 0, 0, 0, 0, DA5, 0);
        chk("sat_cnt3", ic_out_o, 3);
        step(1, 0, 1, 0, 0, DA5, 0);
        chk("sat_regrant", mem_req_o, 1);
        repeat (4) step(0, 0, 0, 1, 0, 0, 0);

        // D$ ack and return in the same cycle at count 2
        repeat (4) step(0, 1, 1, 0, 0, 0, D3C);
        step(0, 1, 0, 0, 0, 0, D3C);
        step(0, 1, 1, 1, 1, 0, D3C);
        chk("sim_ack", dc_ack_o, 1);
        chk("sim_rtrn", dc_rtrn_vld_o, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sim_cnt", dc_out_o, 2);

        // return against an empty D$ counter
        repeat (2) step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("err_rtrn", dc_rtrn_vld_o, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("err_cnt0", dc_out_o, 0);
        chk("err_set", err_o, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", err_o, 1);

        // both held with ack always high: alternation (or D$ priority)
        do_reset();
`ifdef WT_ARB_DCACHE_PRIO_EN
        exp_dc = 1;
`else
        exp_dc = 0;
`endif
        repeat (8) begin
            step(1, 1, 1, 0, 0, DA5, D3C);
            if (ic_ack_o || dc_ack_o) begin
                chk("alt_src", dc_ack_o, exp_dc);
`ifndef WT_ARB_DCACHE_PRIO_EN
                exp_dc = !exp_dc;
`endif
            end
        end

        // asynchronous reset while in GNT_DC with three in flight
        do_reset();
        repeat (6) step(0, 1, 1, 0, 0, 0, D3C);
        step(0, 1, 0, 0, 0, 0, D3C);
        step(0, 1, 0, 0, 0, 0, D3C);
        chk("ar_gnt", mem_req_o, 1);
        chk("ar_cnt3", dc_out_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", mem_req_o, 0);
        chk("ar_cnt", dc_out_o, 0);
        chk("ar_idle", idle_o, 1);
        do_reset();

        // randomized traffic against the model
        ic_pend = 0; dc_pend = 0; ic_v = '0; dc_v = '0;
        for (int i = 0; i < 600; i++) begin
            int  g;
            bit  ak, rv, rs;
            if (!ic_pend && $urandom_range(0, 2) != 0) begin
                ic_pend = 1;
                ic_v = {8{$urandom()}};
            end
            if (!dc_pend && $urandom_range(0, 2) != 0) begin
                dc_pend = 1;
                dc_v = {8{$urandom()}};
            end
            ak = ($urandom_range(0, 9) < 6);
            rs = $urandom_range(0, 1);
            rv = ($urandom_range(0, 9) < 4) && (m_cnt[rs] > 0);
            g = m_gnt;
            step(ic_pend, dc_pend, ak, rv, rs, ic_v, dc_v);
            if (g == 1 && ak) ic_pend = 0;
            if (g == 2 && ak) dc_pend = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
